// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and the address/data
// typedefs used by the register file and its scoreboard.
package cpu_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/cpu_reg_file_if.sv
// Register-file port bundle: two read ports, one writeback port, one issue port,
// plus the scoreboard status outputs. The core drives through master; the file is slave.
interface cpu_reg_file_if
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
);
  localparam int AW = $clog2(NUM_REGS);

  // There is no valid/ready pairing here: wr_en and iss_vld are single-cycle
  // strobes that always complete at the next rising edge; the file never stalls.
  logic [AW-1:0]     rd_addr1;
  logic [AW-1:0]     rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_vld;
  logic [AW-1:0]     iss_dst;
  logic              hazard;
  logic [AW:0]       pend_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_vld, iss_dst,
    input  rd_data1, rd_data2, hazard, pend_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_vld, iss_dst,
    output rd_data1, rd_data2, hazard, pend_cnt
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue and
// cleared on writeback, with read-port hazard detection and a pending count.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                iss_vld,
  input  logic [AW-1:0]       iss_dst,
  input  logic [AW-1:0]       rd_addr1,
  input  logic [AW-1:0]       rd_addr2,
  output logic                hazard,
  output logic [AW:0]         pend_cnt,
  output logic [NUM_REGS-1:0] pending
);

  localparam int CW = AW + 1;

  logic [NUM_REGS-1:0] pend_next;
  logic                wr_fire;
  logic                iss_fire;
  logic                clr1;
  logic                clr2;

  assign wr_fire  = wr_en && (wr_addr != '0);
  assign iss_fire = iss_vld && (iss_dst != '0);

  // Clear is applied before set so an issue in the writeback cycle wins.
  always_comb begin
    pend_next = pending;
    if (wr_fire)  pend_next[wr_addr] = 1'b0;
    if (iss_fire) pend_next[iss_dst] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pend_next;
  end

  // A writeback landing this cycle resolves the hazard for a matching reader.
  assign clr1   = wr_fire && (wr_addr == rd_addr1);
  assign clr2   = wr_fire && (wr_addr == rd_addr2);
  assign hazard = (pending[rd_addr1] & ~clr1) | (pending[rd_addr2] & ~clr2);

  // Bit 0 is always clear, so the count tops out at NUM_REGS-1 and fits in AW+1 bits.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_cnt = pend_cnt + CW'(pending[i]);
    end
  end

endmodule

// File: rtl/cpu_reg_file.sv
// Two-read/one-write CPU register file with r0 hardwired to zero and an issue scoreboard.
// Optional same-cycle write-through on the read ports is enabled by REGFILE_BYPASS_EN.
module cpu_reg_file
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  cpu_reg_file_if.slave bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic                wr_fire;
  logic [DATA_W-1:0]   rd_data1;
  logic [DATA_W-1:0]   rd_data2;
  logic                hazard;
  logic [AW:0]         pend_cnt;
  logic [NUM_REGS-1:0] pending;

  assign wr_fire = bus.wr_en && (bus.wr_addr != '0);

  // Entry 0 is only ever cleared; reads of address 0 are forced to zero anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rd_data1 = (bus.rd_addr1 == '0) ? '0 : mem[bus.rd_addr1];
    rd_data2 = (bus.rd_addr2 == '0) ? '0 : mem[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (bus.wr_addr == bus.rd_addr1)) rd_data1 = bus.wr_data;
    if (wr_fire && (bus.wr_addr == bus.rd_addr2)) rd_data2 = bus.wr_data;
`endif
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_vld  (bus.iss_vld),
    .iss_dst  (bus.iss_dst),
    .rd_addr1 (bus.rd_addr1),
    .rd_addr2 (bus.rd_addr2),
    .hazard   (hazard),
    .pend_cnt (pend_cnt),
    .pending  (pending)
  );

  assign bus.rd_data1 = rd_data1;
  assign bus.rd_data2 = rd_data2;
  assign bus.hazard   = hazard;
  assign bus.pend_cnt = pend_cnt;

endmodule

// File: doc/cpu_reg_file.md
CPU_REG_FILE -- requirements
Module: cpu_reg_file

Interface
REQ-001 Parameters: NUM_REGS, 16, architectural register count, power of two, at least 4.
REQ-002 Parameters: DATA_W, 32, register width in bits.
REQ-003 Derived constant AW = log2(NUM_REGS), used for address width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 rd_addr1, rd_addr2  in  AW each  read port 1 and read port 2 addresses.
REQ-007 rd_data1, rd_data2  out  DATA_W each  read port 1 and read port 2 data; combinational from the address.
REQ-008 wr_en  in  1  writeback strobe.
REQ-009 wr_addr  in  AW  writeback destination.
REQ-010 wr_data  in  DATA_W  writeback value.
REQ-011 iss_vld  in  1  instruction issue strobe; marks a destination pending.
REQ-012 iss_dst  in  AW  destination of the issuing instruction.
REQ-013 hazard  out  1  a source register on a read port has an outstanding write.
REQ-014 pend_cnt  out  AW+1  number of registers currently pending.

Function
REQ-015 Register 0 SHALL read as zero at all times; writes and issues to address 0 SHALL be ignored.
REQ-016 When wr_en is 1 and wr_addr is not 0, the array SHALL capture wr_data at the rising edge, so the value is visible on read ports in the next cycle.
REQ-017 Each read port SHALL return the array contents combinationally, subject to REQ-030.
REQ-018 Scoreboard: a NUM_REGS-bit pending vector SHALL be kept, with bit 0 tied to 0.
REQ-019 iss_vld=1 with iss_dst!=0 SHALL set pending[iss_dst] at the edge.
REQ-020 wr_en=1 with wr_addr!=0 SHALL clear pending[wr_addr] at the edge.
REQ-021 If issue and writeback target the same register in the same cycle, the bit SHALL end up set; the new issue wins.
REQ-022 Issue to an already-pending register SHALL leave the bit set; no error is raised.
REQ-023 Writeback to a non-pending register SHALL still update the array and leave the bit clear.
REQ-024 hazard SHALL equal (pending[rd_addr1] & ~clr1) | (pending[rd_addr2] & ~clr2), where clrN = wr_en & (wr_addr==rd_addrN) & (wr_addr!=0).
REQ-025 hazard SHALL be 0 whenever a read address is 0 on that port.
REQ-026 pend_cnt SHALL equal the population count of the registered pending vector.
REQ-027 pend_cnt SHALL saturate only at NUM_REGS-1, which it cannot exceed structurally.

Reset
REQ-028 While rst=1 at an edge, all array entries and all pending bits SHALL be cleared, and wr_en and iss_vld SHALL be ignored in that cycle.
REQ-029 After reset: rd_data1=rd_data2=0, hazard=0, pend_cnt=0. Reset asserted mid-operation SHALL discard all outstanding pending state.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN:
- Defined: if wr_en=1, wr_addr!=0 and wr_addr==rd_addrN, rd_dataN SHALL return wr_data in the same cycle (write-through).
- Undefined: rd_dataN SHALL return the pre-write array value in that cycle.
- Scoreboard and hazard behaviour SHALL be identical in both builds.

Structure
REQ-031 A shared package cpu_pkg SHALL hold the default NUM_REGS and DATA_W constants and the typedefs reg_addr_t and reg_data_t; cpu_reg_file SHALL import it.
REQ-032 A single sub-module, reg_scoreboard, SHALL contain the pending vector, the hazard logic and the popcount; the array and bypass SHALL remain in cpu_reg_file.

Verification
REQ-033 Write then read: write 0xDEADBEEF to r5; next cycle rd_addr1=5 -> rd_data1=0xDEADBEEF.
REQ-034 r0 protection: write 0x1234 to r0 -> rd_data1=0 for rd_addr1=0, and iss_dst=0 leaves pend_cnt=0.
REQ-035 Same-cycle write and read of r7 with 0xA5A5A5A5:
- With REGFILE_BYPASS_EN -> rd_data2=0xA5A5A5A5.
- Without it -> the prior value (0 after reset).
REQ-036 Scoreboard lifecycle, each step on a successive edge:
- Issue r3 -> pend_cnt=1; rd_addr1=3 -> hazard=1.
- In the writeback cycle for r3 -> hazard=0.
- Next edge -> pend_cnt=0.
REQ-037 Issue and writeback of r9 in the same cycle, r9 previously pending -> r9 remains pending, pend_cnt unchanged, array holds the new data.
REQ-038 Reset mid-operation: issue r2, r4, r6 and write 0xFF to r4, then assert rst for one cycle -> pend_cnt=0, hazard=0, all reads 0.
